// File: rtl/output_port.sv
// Buffered CPU-to-pins output port: write FIFO feeding a four-phase strobe/ack transmitter.
// Optional readback of the driven pins is enabled with OUTPUT_PORT_READBACK_EN.
module output_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             busy,
    output logic [WIDTH-1:0] pins_out,
    output logic             strobe,
    input  logic             ack
`ifdef OUTPUT_PORT_READBACK_EN
    ,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RELEASE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic [WIDTH-1:0] pins_q;
    logic             strobe_q;
    logic             overflow_q;
    logic             push;
    logic             pop;

    // Both flags come from the pre-edge count, so a write while full is dropped
    // even when the transmitter pops in the same cycle.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = wr_en & ~full;
    assign pop   = (state_q == IDLE) & ~empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset: clearing the pointers is enough to discard queued data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transmit handshake; pins only change on the IDLE-to-DRIVE transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pins_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pins_q   <= mem_q[rd_ptr_q];
                        strobe_q <= 1'b1;
                        state_q  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (ack) begin
                        strobe_q <= 1'b0;
                        state_q  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    strobe_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign pins_out = pins_q;
    assign strobe   = strobe_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) | ~empty;

`ifdef OUTPUT_PORT_READBACK_EN
    assign data_out = rd_en ? pins_q : '0;
`endif

endmodule

// File: tb/tb_output_port.sv
// Directed bench for output_port: scoreboard of written bytes checked against each presented byte.
module tb_output_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             busy;
    logic [WIDTH-1:0] pins_out;
    logic             strobe;
    logic             ack = 1'b0;
`ifdef OUTPUT_PORT_READBACK_EN
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] data_out;
`endif

    output_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .busy     (busy),
        .pins_out (pins_out),
        .strobe   (strobe),
        .ack      (ack)
`ifdef OUTPUT_PORT_READBACK_EN
        ,
        .rd_en    (rd_en),
        .data_out (data_out)
`endif
    );

    always #5 clk = ~clk;

    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               fifo_cnt = 0;
    logic             ovf_exp = 1'b0;
    logic [WIDTH-1:0] last_b = '0;
    logic             saw55 = 1'b0;

    always @(negedge clk) begin
        if (strobe === 1'b1 && pins_out === 8'h55) saw55 = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        logic accept;
        accept = (fifo_cnt < DEPTH);
        wr_en   = 1'b1;
        data_in = d;
        step();
        wr_en = 1'b0;
        if (accept) begin
            exp_q.push_back(d);
            fifo_cnt++;
        end else begin
            ovf_exp = 1'b1;
        end
        $display("[TB] write %02h %s", d, accept ? "queued" : "dropped");
        check("overflow_after_write", overflow, ovf_exp);
    endtask

    task automatic wait_strobe(output int n);
        logic [WIDTH-1:0] e;
        n = 0;
        do begin
            step();
            n++;
        end while (strobe !== 1'b1 && n < 20);
        check("strobe_rise", strobe, 1);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: observed byte %02h presented, expected no byte", pins_out);
        end else begin
            e = exp_q.pop_front();
            fifo_cnt--;
            last_b = e;
            $display("[TB] presented %02h expected %02h", pins_out, e);
            check("pins_presented", pins_out, e);
        end
    endtask

    task automatic finish_hs(input int d);
        repeat (d) begin
            step();
            check("strobe_hold", strobe, 1);
            check("pins_hold", pins_out, last_b);
        end
        ack = 1'b1;
        step();
        check("strobe_fall", strobe, 0);
        ack = 1'b0;
        step();
        check("pins_after_release", pins_out, last_b);
    endtask

    task automatic handshake(input int d);
        int n;
        wait_strobe(n);
        finish_hs(d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        step();
        step();
        check("rst_pins", pins_out, 0);
        check("rst_strobe", strobe, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Single byte, ack two cycles after strobe
        wr(8'h3C);
        check("t1_empty_after_write", empty, 0);
        wait_strobe(n);
        check("t1_latency", n, 1);
        finish_hs(2);
        check("t1_busy_idle", busy, 0);

        // One byte held in DRIVE while four more fill the FIFO
        wr(8'h10);
        wait_strobe(n);
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        check("t2_not_full_3", full, 0);
        wr(8'h44);
        check("t2_full_4", full, 1);
        wr(8'h55);
        check("t3_overflow_set", overflow, 1);
        finish_hs(1);
        repeat (4) handshake(0);
        check("t2_empty_end", empty, 1);
        check("t3_overflow_sticky", overflow, 1);

        // Pointer wrap with order preserved
        wr(8'hA1);
        wr(8'hA2);
        wr(8'hA3);
        repeat (3) handshake(0);
        wr(8'hB1);
        wr(8'hB2);
        wr(8'hB3);
        repeat (3) handshake(1);
        check("t3_empty_wrap", empty, 1);
        check("t3_never_55", saw55, 0);
        check("t3_overflow_still", overflow, 1);

        // Asynchronous reset mid-transfer
        wr(8'hA5);
        wait_strobe(n);
        #2;
        rst = 1'b1;
        #1;
        check("t4_rst_pins", pins_out, 0);
        check("t4_rst_strobe", strobe, 0);
        check("t4_rst_empty", empty, 1);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_overflow", overflow, 0);
        exp_q.delete();
        fifo_cnt = 0;
        ovf_exp  = 1'b0;
        #3;
        rst = 1'b0;
        step();
        wr(8'h5A);
        handshake(0);
        check("t4_busy_after", busy, 0);

        // Ack held high while idle is ignored
        ack = 1'b1;
        repeat (3) step();
        check("t5_idle_strobe", strobe, 0);
        check("t5_idle_busy", busy, 0);
        wr(8'h77);
        wait_strobe(n);
        step();
        check("t5_strobe_drop", strobe, 0);
        ack = 1'b0;
        step();
        check("t5_busy_done", busy, 0);
        check("t5_pins_hold", pins_out, 8'h77);

`ifdef OUTPUT_PORT_READBACK_EN
        wr(8'hC3);
        handshake(0);
        rd_en = 1'b1;
        #1;
        check("t6_readback_on", data_out, 8'hC3);
        rd_en = 1'b0;
        #1;
        check("t6_readback_off", data_out, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
